// File: rtl/ucb_pkg.sv
// Shared types and helpers for the UCB arm selector.
// State encoding, inform word layout, arm codes, fp32 ordering key.
package ucb_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CMP,
    S_DONE
  } state_t;

  localparam int ROUND_LSB = 16;
  localparam int ARM_LSB   = 0;

  localparam logic [1:0] ARM_1 = 2'b01;
  localparam logic [1:0] ARM_2 = 2'b10;

  function automatic logic fp32_is_nan(input logic [31:0] x);
    return (&x[30:23]) && (|x[22:0]);
  endfunction

  // Monotonic unsigned key; -0 folded onto +0 so they compare equal.
  function automatic logic [31:0] fp32_key(input logic [31:0] x);
    logic [31:0] n;
    n = (x == 32'h8000_0000) ? 32'h0 : x;
    return n[31] ? ~n : (n | 32'h8000_0000);
  endfunction

endpackage

// File: rtl/ucb_arm_selector_cmp.sv
// fp32_ordered_cmp: combinational total-order compare of two floats.
// NaN ranks below every number; two NaNs compare equal.
module fp32_ordered_cmp
  import ucb_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        a_gt_b,
  output logic        eq
);

  logic        a_nan;
  logic        b_nan;
  logic [31:0] ka;
  logic [31:0] kb;

  assign a_nan = fp32_is_nan(a);
  assign b_nan = fp32_is_nan(b);
  assign ka    = fp32_key(a);
  assign kb    = fp32_key(b);

  always_comb begin
    a_gt_b = 1'b0;
    eq     = 1'b0;
    unique case (1'b1)
      (a_nan & b_nan): begin
        eq = 1'b1;
      end
      (a_nan & ~b_nan): begin
        a_gt_b = 1'b0;
      end
      (~a_nan & b_nan): begin
        a_gt_b = 1'b1;
      end
      (~a_nan & ~b_nan): begin
        a_gt_b = ka > kb;
        eq     = ka == kb;
      end
    endcase
  end

endmodule

// File: rtl/ucb_arm_selector.sv
// Two-arm UCB agent: play each arm once, then greedily pick the larger Q.
// Optional per-arm pull counters when UCB_SEL_STATS_EN is defined.
module ucb_arm_selector
  import ucb_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1024,
  parameter int ROUND_W     = 16,
  parameter int MAX_ROUNDS  = 0
) (
  input  logic               clk,
  input  logic               s_aresetn,
  input  logic               enable,
  input  logic [31:0]        Q1_t,
  input  logic               float_Q1_valid,
  input  logic [31:0]        Q2_t,
  input  logic               float_Q2_valid,
  output logic [31:0]        inform,
  output logic               inform_valid,
  output logic [1:0]         arm_sel,
  output logic [ROUND_W-1:0] round_cnt,
  output logic               busy,
  output logic               timeout_err
`ifdef UCB_SEL_STATS_EN
  ,
  output logic [ROUND_W-1:0] pull_cnt1,
  output logic [ROUND_W-1:0] pull_cnt2
`endif
);

  localparam int TW = $clog2(TIMEOUT_CYC);

  state_t             state;
  state_t             state_nx;
  logic [TW-1:0]      timer;
  logic [31:0]        q1;
  logic [31:0]        q2;
  logic               have1;
  logic               have2;
  logic               in_wait;
  logic               both;
  logic               tmo;
  logic               issue;
  logic               rounds_hit;
  logic               q2_gt;
  logic               q_eq;
  logic [1:0]         arm_cmp;
  logic [1:0]         arm_pick;
  logic [1:0]         arm_nx;
  logic [ROUND_W-1:0] round_base;
  logic [31:0]        inform_nx;

  fp32_ordered_cmp u_cmp (
    .a      (q2),
    .b      (q1),
    .a_gt_b (q2_gt),
    .eq     (q_eq)
  );

  assign in_wait = state == S_WAIT;
  assign both    = in_wait
                 & (have1 | float_Q1_valid)
                 & (have2 | float_Q2_valid);
  assign tmo     = in_wait & ~both
                 & (timer == TW'(TIMEOUT_CYC - 1));
  assign issue   = state_nx == S_ISSUE;
  assign busy    = state != S_IDLE;
  assign arm_cmp = (q2_gt & ~q_eq) ? ARM_2 : ARM_1;

  assign rounds_hit = (MAX_ROUNDS != 0)
                    && (round_cnt == ROUND_W'(MAX_ROUNDS));

  assign round_base = (state == S_IDLE) ? '0 : round_cnt;

  always_comb begin
    arm_pick = arm_cmp;
    unique case (1'b1)
      (round_cnt == '0):          arm_pick = ARM_1;
      (round_cnt == ROUND_W'(1)): arm_pick = ARM_2;
      (round_cnt >  ROUND_W'(1)): arm_pick = arm_cmp;
    endcase
  end

  always_comb begin
    state_nx = state;
    arm_nx   = arm_sel;
    unique case (state)
      S_IDLE: begin
        if (enable) begin
          state_nx = S_ISSUE;
          arm_nx   = ARM_1;
        end
      end
      S_ISSUE: state_nx = S_WAIT;
      // Timeout keeps arm_nx = arm_sel: the same arm is re-issued.
      S_WAIT: begin
        if (both)
          state_nx = S_CMP;
        else if (tmo)
          state_nx = S_ISSUE;
      end
      S_CMP: begin
        if (rounds_hit)
          state_nx = S_DONE;
        else if (!enable)
          state_nx = S_IDLE;
        else begin
          state_nx = S_ISSUE;
          arm_nx   = arm_pick;
        end
      end
      S_DONE: begin
        if (!enable)
          state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    inform_nx = '0;
    inform_nx[ROUND_LSB +: ROUND_W] = round_base;
    inform_nx[ARM_LSB +: 2]         = arm_nx;
  end

  always_ff @(posedge clk or negedge s_aresetn) begin
    if (!s_aresetn) begin
      state        <= S_IDLE;
      inform       <= '0;
      inform_valid <= 1'b0;
      arm_sel      <= '0;
      round_cnt    <= '0;
      timeout_err  <= 1'b0;
      timer        <= '0;
      q1           <= '0;
      q2           <= '0;
      have1        <= 1'b0;
      have2        <= 1'b0;
    end else begin
      state        <= state_nx;
      inform_valid <= issue;
      if (issue) begin
        inform    <= inform_nx;
        arm_sel   <= arm_nx;
        round_cnt <= round_base + ROUND_W'(1);
      end
      if (tmo)
        timeout_err <= 1'b1;
      timer <= in_wait ? timer + TW'(1) : '0;
      if (in_wait && float_Q1_valid) begin
        q1    <= Q1_t;
        have1 <= 1'b1;
      end
      if (in_wait && float_Q2_valid) begin
        q2    <= Q2_t;
        have2 <= 1'b1;
      end
      if (tmo || state == S_CMP) begin
        have1 <= 1'b0;
        have2 <= 1'b0;
      end
    end
  end

`ifdef UCB_SEL_STATS_EN
  always_ff @(posedge clk or negedge s_aresetn) begin
    if (!s_aresetn) begin
      pull_cnt1 <= '0;
      pull_cnt2 <= '0;
    end else if (issue) begin
      if (state == S_IDLE) begin
        pull_cnt1 <= ROUND_W'(arm_nx == ARM_1);
        pull_cnt2 <= ROUND_W'(arm_nx == ARM_2);
      end else if (arm_nx == ARM_1) begin
        if (~&pull_cnt1)
          pull_cnt1 <= pull_cnt1 + ROUND_W'(1);
      end else if (arm_nx == ARM_2) begin
        if (~&pull_cnt2)
          pull_cnt2 <= pull_cnt2 + ROUND_W'(1);
      end
    end
  end
`endif

endmodule
